// File: rtl/morse_keyer_pkg.sv
// Shared types, symbol codes, unit multiples and the BCD6 increment used by the keyer.
package morse_keyer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_t;

    localparam logic [2:0] SYM_DOT  = 3'd0;
    localparam logic [2:0] SYM_DASH = 3'd1;
    localparam logic [2:0] SYM_LGAP = 3'd2;
    localparam logic [2:0] SYM_WGAP = 3'd3;

    localparam logic [3:0] UNITS_DOT  = 4'd1;
    localparam logic [3:0] UNITS_DASH = 4'd3;
    localparam logic [3:0] UNITS_ISG  = 4'd1;
    localparam logic [3:0] UNITS_LGAP = 4'd2;
    localparam logic [3:0] UNITS_WGAP = 4'd6;

    function automatic logic [23:0] bcd6_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_keyer_unit_timer.sv
// BCD6 subpulse counter with latched unit length and a BCD6 units count;
// flags the ce on which the units count would reach the current target.
module morse_keyer_unit_timer
    import morse_keyer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        run,
    input  logic        start,
    input  logic        restart,
    input  logic        clear,
    input  logic [23:0] len_in,
    input  logic [3:0]  target,
    output logic        phase_done
);

    logic [23:0] len_q,   len_d;
    logic [23:0] pulse_q, pulse_d;
    logic [23:0] units_q, units_d;
    logic [23:0] units_inc;
    logic        unit_done;

    assign unit_done  = run && ce && (pulse_q == len_q);
    assign units_inc  = bcd6_inc(units_q);
    assign phase_done = unit_done && (units_inc == {20'd0, target});

    always_comb begin
        len_d   = len_q;
        pulse_d = pulse_q;
        units_d = units_q;
        if (clear) begin
            pulse_d = '0;
            units_d = '0;
        end else if (start) begin
            // A zero length would never match the counter, so it runs as one ce per unit.
            len_d   = (len_in == 24'd0) ? 24'h000001 : len_in;
            pulse_d = 24'h000001;
            units_d = '0;
        end else if (restart) begin
            pulse_d = 24'h000001;
            units_d = '0;
        end else if (unit_done) begin
            pulse_d = 24'h000001;
            units_d = units_inc;
        end else if (run && ce) begin
            pulse_d = bcd6_inc(pulse_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q   <= 24'h000001;
            pulse_q <= '0;
            units_q <= '0;
        end else begin
            len_q   <= len_d;
            pulse_q <= pulse_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts symbols over valid/ready and times key_out in units of
// subpulses_count ce ticks.
module morse_keyer
    import morse_keyer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [23:0] subpulses_count,
    input  logic        abort,
    input  logic        sym_valid,
    input  logic [2:0]  sym_code,
    output logic        sym_ready,
    output logic        key_out,
    output logic        busy,
    output logic        sym_err
);

    state_t      state_q,  state_d;
    logic        key_q,    key_d;
    logic        err_q,    err_d;
    logic [3:0]  target_q, target_d;
    logic        accept;
    logic        restart;
    logic        phase_done;

    assign sym_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign key_out   = key_q;
    assign sym_err   = err_q;

    morse_keyer_unit_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .run        (busy),
        .start      (accept),
        .restart    (restart),
        .clear      (abort),
        .len_in     (subpulses_count),
        .target     (target_q),
        .phase_done (phase_done)
    );

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        err_d    = 1'b0;
        target_d = target_q;
        accept   = 1'b0;
        restart  = 1'b0;
        if (abort) begin
            state_d  = ST_IDLE;
            key_d    = 1'b0;
            target_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sym_valid) begin
                        accept = 1'b1;
                        case (sym_code)
                            SYM_DOT:  begin state_d = ST_MARK;  key_d = 1'b1; target_d = UNITS_DOT;  end
                            SYM_DASH: begin state_d = ST_MARK;  key_d = 1'b1; target_d = UNITS_DASH; end
                            SYM_LGAP: begin state_d = ST_SPACE; target_d = UNITS_LGAP; end
                            SYM_WGAP: begin state_d = ST_SPACE; target_d = UNITS_WGAP; end
                            default:  err_d = 1'b1;
                        endcase
                    end
                end
                ST_MARK: begin
                    if (phase_done) begin
                        state_d  = ST_SPACE;
                        key_d    = 1'b0;
                        target_d = UNITS_ISG;
                        restart  = 1'b1;
                    end
                end
                ST_SPACE: begin
                    if (phase_done) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    key_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            key_q    <= 1'b0;
            err_q    <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            err_q    <= err_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Directed and randomized checks of morse_keyer against a ce-countdown reference model.
module tb_morse_keyer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [23:0] subpulses_count;
    logic        abort;
    logic        sym_valid;
    logic [2:0]  sym_code;
    logic        sym_ready;
    logic        key_out;
    logic        busy;
    logic        sym_err;

    int checks = 0;
    int errors = 0;

    // reference model: phase 0=idle 1=mark 2=space, m_rem = ce ticks left in phase
    int   m_phase = 0;
    int   m_rem   = 0;
    int   m_len   = 1;
    bit   m_err   = 0;
    bit   m_acc   = 0;
    int   cyc     = 0;
    int   ce_period = 1;

    morse_keyer dut (
        .clk             (clk),
        .rst             (rst),
        .ce              (ce),
        .subpulses_count (subpulses_count),
        .abort           (abort),
        .sym_valid       (sym_valid),
        .sym_code        (sym_code),
        .sym_ready       (sym_ready),
        .key_out         (key_out),
        .busy            (busy),
        .sym_err         (sym_err)
    );

    always #5 clk = ~clk;

    function automatic int bcd_to_int(input logic [23:0] b);
        int v = 0;
        int w = 1;
        for (int i = 0; i < 6; i++) begin
            v = v + int'((b >> (4*i)) & 24'hF) * w;
            w = w * 10;
        end
        return v;
    endfunction

    function automatic logic [23:0] int_to_bcd(input int n);
        logic [23:0] r = '0;
        int          x = n;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        cyc++;
        if (ce_period == 0) ce = 1'($urandom_range(0, 1));
        else                ce = (cyc % ce_period == 0);
        @(posedge clk);
        m_acc = 0;
        m_err = 0;
        if (abort) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (sym_valid) begin
                m_acc = 1;
                m_len = bcd_to_int(subpulses_count);
                if (m_len == 0) m_len = 1;
                case (sym_code)
                    3'd0:    begin m_phase = 1; m_rem = 1 * m_len; end
                    3'd1:    begin m_phase = 1; m_rem = 3 * m_len; end
                    3'd2:    begin m_phase = 2; m_rem = 2 * m_len; end
                    3'd3:    begin m_phase = 2; m_rem = 6 * m_len; end
                    default: m_err = 1;
                endcase
            end
        end else if (ce) begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_phase == 1) begin m_phase = 2; m_rem = m_len; end
                else              m_phase = 0;
            end
        end
        #1;
        chk("key_out",   32'(key_out),   32'(m_phase == 1));
        chk("busy",      32'(busy),      32'(m_phase != 0));
        chk("sym_ready", 32'(sym_ready), 32'(m_phase == 0));
        chk("sym_err",   32'(sym_err),   32'(m_err));
    endtask

    task automatic send(input logic [2:0] code);
        int n = 0;
        sym_valid = 1'b1;
        sym_code  = code;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 200);
        chk("accept_timeout", 32'(m_acc), 32'd1);
        sym_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_phase != 0 && n < 5000) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(m_phase == 0), 32'd1);
    endtask

    logic [23:0] s_tab [8];

    initial begin
        s_tab = '{24'h000000, 24'h000001, 24'h000002, 24'h000003,
                  24'h000009, 24'h000010, 24'h000011, 24'h000012};
        rst = 1'b1; ce = 1'b0; abort = 1'b0; sym_valid = 1'b0;
        sym_code = 3'd0; subpulses_count = 24'h000003;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_key",   32'(key_out),   32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ready", 32'(sym_ready), 32'd1);
        chk("rst_err",   32'(sym_err),   32'd0);
        chk("rst_len",   32'(dut.u_timer.len_q), 32'h1);

        // single DOT, S=3, ce always high
        ce_period = 1;
        subpulses_count = 24'h000003;
        send(3'd0);
        wait_idle();
        tick();

        // back-to-back DASH, DOT, WORD_GAP with S=2
        subpulses_count = 24'h000002;
        send(3'd1);
        wait_idle();
        send(3'd0);
        wait_idle();
        send(3'd3);
        wait_idle();
        tick();

        // zero length with ce every 4th clock
        ce_period = 4;
        subpulses_count = 24'h000000;
        send(3'd0);
        wait_idle();
        tick();

        // max length latched, input changed mid-mark, counter digits spot-checked
        ce_period = 1;
        subpulses_count = 24'h999999;
        send(3'd0);
        subpulses_count = 24'h000005;
        repeat (30) tick();
        chk("pulse_digits", 32'(dut.u_timer.pulse_q), 32'(int_to_bcd(31)));
        chk("len_latched",  32'(dut.u_timer.len_q),   32'h999999);
        chk("units_zero",   32'(dut.u_timer.units_q), 32'h0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // invalid code
        send(3'd5);
        tick();
        tick();

        // abort mid-DASH
        subpulses_count = 24'h000002;
        send(3'd1);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // abort in IDLE blocks an offered symbol
        sym_valid = 1'b1;
        sym_code  = 3'd0;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        sym_valid = 1'b0;
        tick();

        // async reset between edges mid-MARK
        subpulses_count = 24'h000005;
        send(3'd1);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_key",  32'(key_out), 32'd0);
        chk("async_rst_busy", 32'(busy),    32'd0);
        m_phase = 0;
        m_err   = 0;
        #1 rst = 1'b0;
        subpulses_count = 24'h000003;
        send(3'd0);
        wait_idle();
        tick();

        // randomized traffic with random ce, lengths, codes and occasional abort
        ce_period = 0;
        for (int i = 0; i < 3000; i++) begin
            sym_valid       = ($urandom_range(0, 3) != 0);
            sym_code        = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
                                                          : 3'($urandom_range(0, 3));
            subpulses_count = s_tab[$urandom_range(0, 7)];
            abort           = ($urandom_range(0, 63) == 0);
            tick();
        end
        abort     = 1'b0;
        sym_valid = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
